// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32 load/store unit.
// Covers funct3 encodings, response error codes, FSM states and access sizes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FMT_B = 2'b00;
  localparam logic [1:0] FMT_H = 2'b01;
  localparam logic [1:0] FMT_W = 2'b10;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_FAULT      = 2'b10,
    ERR_ILLEGAL    = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  function automatic logic [2:0] format_bytes(input logic [1:0] fmt);
    case (fmt)
      FMT_B:   return 3'd1;
      FMT_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake and RAM data port bundle for the load/store unit.
// The slave modport is the LSU; the master side is the execute stage plus the RAM.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [1:0]            resp_err;

  logic                  ram_we;
  logic [1:0]            ram_format;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_we, ram_format, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_we, ram_format, ram_addr, ram_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational request classifier (funct3/alignment/range -> error, format)
// and load data extender (funct3 + RAM read data -> RV32 result).
module lsu_align
  import lsu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0000_0100
) (
  input  logic                  chk_we,
  input  logic [2:0]            chk_funct3,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  output logic [1:0]            chk_err,
  output logic [1:0]            chk_format,
  input  logic [2:0]            ext_funct3,
  input  logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [DATA_WIDTH-1:0] ext_data
);

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic                illegal;
  logic                misaligned;
  logic                fault;
  logic [ADDR_WIDTH:0] first;
  logic [ADDR_WIDTH:0] last;
  logic [ADDR_WIDTH:0] limit;

  // One extra address bit keeps addr+bytes-1 from wrapping into the valid window.
  always_comb begin
    chk_format = chk_funct3[1:0];
    if (chk_we)
      illegal = (chk_funct3 != F3_B) && (chk_funct3 != F3_H) && (chk_funct3 != F3_W);
    else
      illegal = (chk_funct3 == 3'b011) || (chk_funct3[2:1] == 2'b11);
    misaligned = ((chk_format == FMT_H) && chk_addr[0]) ||
                 ((chk_format == FMT_W) && (chk_addr[1:0] != 2'b00));
    first = {1'b0, chk_addr};
    last  = first + {{(ADDR_WIDTH-2){1'b0}}, format_bytes(chk_format)} - ONE;
    limit = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    fault = (first < {1'b0, MEM_BASE}) || (last >= limit);
    if (illegal)         chk_err = ERR_ILLEGAL;
    else if (misaligned) chk_err = ERR_MISALIGNED;
    else if (fault)      chk_err = ERR_FAULT;
    else                 chk_err = ERR_OK;
  end

  always_comb begin
    case (ext_funct3)
      F3_B:    ext_data = {{(DATA_WIDTH-8){ext_rdata[7]}}, ext_rdata[7:0]};
      F3_H:    ext_data = {{(DATA_WIDTH-16){ext_rdata[15]}}, ext_rdata[15:0]};
      F3_BU:   ext_data = {{(DATA_WIDTH-8){1'b0}}, ext_rdata[7:0]};
      F3_HU:   ext_data = {{(DATA_WIDTH-16){1'b0}}, ext_rdata[15:0]};
      default: ext_data = ext_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32 load/store unit: accepts one request in IDLE, spends one ACCESS cycle on
// the RAM port for legal requests, then holds a registered response until taken.
module lsu
  import lsu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0000_0100
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  state_e                state;
  state_e                next_state;
  logic                  lat_we;
  logic [2:0]            lat_funct3;
  logic [1:0]            lat_format;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            err_q;
  logic [1:0]            chk_err;
  logic [1:0]            chk_format;
  logic [DATA_WIDTH-1:0] ext_data;

  lsu_align #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_BASE   (MEM_BASE),
    .MEM_SIZE   (MEM_SIZE)
  ) u_align (
    .chk_we     (bus.req_we),
    .chk_funct3 (bus.req_funct3),
    .chk_addr   (bus.req_addr),
    .chk_err    (chk_err),
    .chk_format (chk_format),
    .ext_funct3 (lat_funct3),
    .ext_rdata  (bus.ram_rdata),
    .ext_data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Requests that fail classification skip ACCESS so the RAM is never touched.
  always_comb begin
    next_state     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_we     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = (chk_err == ERR_OK) ? ACCESS : RESP;
      end
      ACCESS: begin
        bus.ram_we = lat_we;
        next_state = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_format <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= ERR_OK;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        lat_we     <= bus.req_we;
        lat_funct3 <= bus.req_funct3;
        lat_format <= chk_format;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
        if (chk_err != ERR_OK) begin
          rdata_q <= '0;
          err_q   <= chk_err;
        end
      end
      if (state == ACCESS) begin
        rdata_q <= lat_we ? '0 : ext_data;
        err_q   <= ERR_OK;
      end
    end
  end

  assign bus.ram_addr   = lat_addr;
  assign bus.ram_format = lat_format;
  assign bus.ram_wdata  = lat_wdata;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu with a 256-byte RAM model and a response scoreboard.
module tb_lsu;
  import lsu_pkg::*;

  localparam logic [31:0] B = 32'h8000_0000;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
  } req_t;

  logic clk;
  logic rst_n;
  lsu_if bus();

  lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  req_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         we_count = 0;
  logic [7:0] mem [256] = '{default: 8'h00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: little-endian bytes at ram_addr - MEM_BASE, read masked by format.
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      mem[bus.ram_addr[7:0]] <= bus.ram_wdata[7:0];
      if (bus.ram_format != 2'b00) mem[bus.ram_addr[7:0] + 8'd1] <= bus.ram_wdata[15:8];
      if (bus.ram_format == 2'b10) begin
        mem[bus.ram_addr[7:0] + 8'd2] <= bus.ram_wdata[23:16];
        mem[bus.ram_addr[7:0] + 8'd3] <= bus.ram_wdata[31:24];
      end
    end
  end

  always_comb begin
    bus.ram_rdata = 32'h0;
    case (bus.ram_format)
      2'b00:   bus.ram_rdata = {24'h0, mem[bus.ram_addr[7:0]]};
      2'b01:   bus.ram_rdata = {16'h0, mem[bus.ram_addr[7:0] + 8'd1], mem[bus.ram_addr[7:0]]};
      default: bus.ram_rdata = {mem[bus.ram_addr[7:0] + 8'd3], mem[bus.ram_addr[7:0] + 8'd2],
                                mem[bus.ram_addr[7:0] + 8'd1], mem[bus.ram_addr[7:0]]};
    endcase
  end

  always @(negedge clk) if (bus.ram_we === 1'b1) we_count++;

  function automatic req_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] err);
    req_t r;
    r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.err = err;
    return r;
  endfunction

  task automatic send_req(input req_t r, output bit timeout);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = r.we;
    bus.req_funct3 = r.f3;
    bus.req_addr   = r.addr;
    bus.req_wdata  = r.wdata;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready === 1'b1) begin timeout = 1'b0; break; end
      @(negedge clk);
    end
    if (!timeout) begin
      @(posedge clk);
      sb.push_back(r);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [31:0] rdata, output logic [1:0] err, output req_t e,
                          output int lat, output bit timeout);
    lat = 0; timeout = 1'b1; e = '0; rdata = '0; err = '0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (bus.resp_valid === 1'b1) begin timeout = 1'b0; break; end
      lat++;
      @(negedge clk);
    end
    if (!timeout) begin
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      if (sb.size() > 0) e = sb.pop_front();
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 2'b00) begin failures++; $display("[TB] FAIL reset_resp_err: got %b expected 00", bus.resp_err); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 32'h0 || bus.ram_wdata !== 32'h0 || bus.ram_format !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_ram_port: got addr=%h wdata=%h fmt=%b expected zeros", bus.ram_addr, bus.ram_wdata, bus.ram_format);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_load_store();
    req_t tbl[$];
    req_t e;
    logic [31:0] rd;
    logic [1:0] er;
    int lat, w0;
    bit to;
    tbl.push_back(mk(1, F3_W,  B + 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00));
    tbl.push_back(mk(0, F3_W,  B + 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00));
    tbl.push_back(mk(1, F3_B,  B + 32'h21, 32'hAAAA_AA80, 32'h0, 2'b00));
    tbl.push_back(mk(0, F3_B,  B + 32'h21, 32'h0, 32'hFFFF_FF80, 2'b00));
    tbl.push_back(mk(0, F3_BU, B + 32'h21, 32'h0, 32'h0000_0080, 2'b00));
    tbl.push_back(mk(0, F3_H,  B + 32'h20, 32'h0, 32'hFFFF_8000, 2'b00));
    tbl.push_back(mk(0, F3_HU, B + 32'h20, 32'h0, 32'h0000_8000, 2'b00));
    tbl.push_back(mk(1, F3_H,  B + 32'h22, 32'h5555_7F01, 32'h0, 2'b00));
    tbl.push_back(mk(0, F3_H,  B + 32'h22, 32'h0, 32'h0000_7F01, 2'b00));
    tbl.push_back(mk(0, F3_W,  B + 32'h20, 32'h0, 32'h7F01_8000, 2'b00));
    tbl.push_back(mk(0, F3_B,  B + 32'h13, 32'h0, 32'hFFFF_FFDE, 2'b00));
    tbl.push_back(mk(0, F3_BU, B + 32'h12, 32'h0, 32'h0000_00AD, 2'b00));
    tbl.push_back(mk(0, F3_HU, B + 32'h12, 32'h0, 32'h0000_DEAD, 2'b00));
    tbl.push_back(mk(0, F3_H,  B + 32'h10, 32'h0, 32'hFFFF_BEEF, 2'b00));
    foreach (tbl[i]) begin
      w0 = we_count;
      send_req(tbl[i], to);
      checks++;
      if (to) begin failures++; $display("[TB] FAIL load_store[%0d]_accept: got timeout expected req_ready", i); end
      else begin
        get_resp(rd, er, e, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL load_store[%0d]_resp: got timeout expected resp_valid", i); end
        else begin
          checks++; if (rd !== e.rdata) begin failures++; $display("[TB] FAIL load_store[%0d]_rdata: got %h expected %h", i, rd, e.rdata); end
          checks++; if (er !== e.err) begin failures++; $display("[TB] FAIL load_store[%0d]_err: got %b expected %b", i, er, e.err); end
          checks++; if (lat != ((e.err == 2'b00) ? 1 : 0)) begin failures++; $display("[TB] FAIL load_store[%0d]_latency: got %0d expected %0d", i, lat, (e.err == 2'b00) ? 1 : 0); end
        end
        checks++;
        if (we_count - w0 != ((tbl[i].we && tbl[i].err == 2'b00) ? 1 : 0)) begin
          failures++; $display("[TB] FAIL load_store[%0d]_ram_we_cycles: got %0d expected %0d", i, we_count - w0, (tbl[i].we && tbl[i].err == 2'b00) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_errors();
    req_t tbl[$];
    req_t e;
    logic [31:0] rd;
    logic [1:0] er;
    int lat, w0;
    bit to;
    tbl.push_back(mk(0, F3_W,   B + 32'h12,   32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(1, F3_H,   B + 32'h13,   32'h0000_1234, 32'h0, 2'b01));
    tbl.push_back(mk(0, F3_W,   B + 32'h10,   32'h0, 32'hDEAD_BEEF, 2'b00));
    tbl.push_back(mk(0, F3_W,   B + 32'hFC,   32'h0, 32'h0, 2'b00));
    tbl.push_back(mk(0, F3_W,   B + 32'h100,  32'h0, 32'h0, 2'b10));
    tbl.push_back(mk(0, F3_H,   32'h7FFF_FFFE, 32'h0, 32'h0, 2'b10));
    tbl.push_back(mk(0, 3'b011, B + 32'h10,   32'h0, 32'h0, 2'b11));
    tbl.push_back(mk(0, F3_W,   32'hFFFF_FFFC, 32'h0, 32'h0, 2'b10));
    tbl.push_back(mk(1, 3'b100, B + 32'h10,   32'h1111_1111, 32'h0, 2'b11));
    tbl.push_back(mk(0, 3'b110, 32'h7FFF_FFFF, 32'h0, 32'h0, 2'b11));
    tbl.push_back(mk(0, F3_W,   32'h7FFF_FFFF, 32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(0, F3_HU,  B + 32'hFF,   32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(0, F3_HU,  B + 32'hFE,   32'h0, 32'h0, 2'b00));
    tbl.push_back(mk(1, F3_W,   B + 32'h100,  32'h2222_2222, 32'h0, 2'b10));
    tbl.push_back(mk(1, F3_W,   B + 32'hFC,   32'hCAFE_F00D, 32'h0, 2'b00));
    tbl.push_back(mk(0, F3_W,   B + 32'hFC,   32'h0, 32'hCAFE_F00D, 2'b00));
    tbl.push_back(mk(0, F3_W,   B + 32'hFD,   32'h0, 32'h0, 2'b01));
    foreach (tbl[i]) begin
      w0 = we_count;
      send_req(tbl[i], to);
      checks++;
      if (to) begin failures++; $display("[TB] FAIL errors[%0d]_accept: got timeout expected req_ready", i); end
      else begin
        get_resp(rd, er, e, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL errors[%0d]_resp: got timeout expected resp_valid", i); end
        else begin
          checks++; if (rd !== e.rdata) begin failures++; $display("[TB] FAIL errors[%0d]_rdata: got %h expected %h", i, rd, e.rdata); end
          checks++; if (er !== e.err) begin failures++; $display("[TB] FAIL errors[%0d]_err: got %b expected %b", i, er, e.err); end
          checks++; if (lat != ((e.err == 2'b00) ? 1 : 0)) begin failures++; $display("[TB] FAIL errors[%0d]_latency: got %0d expected %0d", i, lat, (e.err == 2'b00) ? 1 : 0); end
        end
        checks++;
        if (we_count - w0 != ((tbl[i].we && tbl[i].err == 2'b00) ? 1 : 0)) begin
          failures++; $display("[TB] FAIL errors[%0d]_ram_we_cycles: got %0d expected %0d", i, we_count - w0, (tbl[i].we && tbl[i].err == 2'b00) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    req_t e, exp_r;
    logic [31:0] rd;
    logic [1:0] er;
    int lat, w0;
    bit to, seen;
    send_req(mk(0, F3_W, B + 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00), to);
    seen = 1'b0;
    if (!to) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.resp_valid === 1'b1) begin seen = 1'b1; break; end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL backpressure_resp: got timeout expected resp_valid"); end
    else begin
      w0 = we_count;
      exp_r = sb[0];
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = B + 32'h10;
      bus.req_wdata  = 32'h0BAD_F00D;
      for (int k = 0; k < 5; k++) begin
        checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold[%0d]_resp_valid: got %b expected 1", k, bus.resp_valid); end
        checks++; if (bus.resp_rdata !== exp_r.rdata) begin failures++; $display("[TB] FAIL hold[%0d]_rdata: got %h expected %h", k, bus.resp_rdata, exp_r.rdata); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold[%0d]_req_ready: got %b expected 0", k, bus.req_ready); end
        @(negedge clk);
      end
      bus.req_valid = 1'b0;
      get_resp(rd, er, e, lat, to);
      checks++; if (to || rd !== e.rdata || er !== e.err) begin
        failures++; $display("[TB] FAIL backpressure_final: got to=%b rdata=%h err=%b expected rdata=%h err=%b", to, rd, er, e.rdata, e.err);
      end
      checks++; if (we_count != w0) begin failures++; $display("[TB] FAIL backpressure_ignored_store: got %0d ram_we cycles expected 0", we_count - w0); end
    end
    send_req(mk(0, F3_W, B + 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00), to);
    if (!to) begin
      get_resp(rd, er, e, lat, to);
      checks++; if (to || rd !== e.rdata) begin failures++; $display("[TB] FAIL backpressure_reload: got %h expected %h", rd, e.rdata); end
    end
  endtask

  task automatic test_back_to_back();
    req_t e, nr;
    logic [31:0] rd;
    logic [1:0] er;
    int lat;
    bit to, seen;
    send_req(mk(0, F3_W, B + 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00), to);
    seen = 1'b0;
    if (!to) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.resp_valid === 1'b1) begin seen = 1'b1; break; end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL b2b_resp: got timeout expected resp_valid"); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.resp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL b2b_first_rdata: got %h expected %h", bus.resp_rdata, e.rdata); end
      nr = mk(0, F3_BU, B + 32'h21, 32'h0, 32'h0000_0080, 2'b00);
      bus.resp_ready = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_we     = nr.we;
      bus.req_funct3 = nr.f3;
      bus.req_addr   = nr.addr;
      bus.req_wdata  = nr.wdata;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL b2b_after_handshake: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.resp_valid);
      end
      @(posedge clk);
      sb.push_back(nr);
      #1;
      bus.req_valid = 1'b0;
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_accept_next: got ready=%b expected 0", bus.req_ready); end
      get_resp(rd, er, e, lat, to);
      checks++; if (to || rd !== e.rdata || lat != 1) begin
        failures++; $display("[TB] FAIL b2b_second: got to=%b rdata=%h lat=%0d expected rdata=%h lat=1", to, rd, lat, e.rdata);
      end
    end
  endtask

  task automatic test_async_reset();
    req_t e;
    logic [31:0] rd;
    logic [1:0] er;
    int lat, w0;
    bit to;
    w0 = we_count;
    send_req(mk(1, F3_W, B + 32'h40, 32'h1122_3344, 32'h0, 2'b00), to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL arst_accept: got timeout expected req_ready"); end
    else begin
      checks++; if (bus.ram_we !== 1'b1) begin failures++; $display("[TB] FAIL arst_access_we: got %b expected 1", bus.ram_we); end
      checks++; if (bus.ram_addr !== B + 32'h40 || bus.ram_wdata !== 32'h1122_3344 || bus.ram_format !== 2'b10) begin
        failures++; $display("[TB] FAIL arst_access_port: got addr=%h wdata=%h fmt=%b expected %h/11223344/10", bus.ram_addr, bus.ram_wdata, bus.ram_format, B + 32'h40);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("[TB] FAIL arst_we_drop: got %b expected 0", bus.ram_we); end
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL arst_release: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.resp_valid);
      end
      checks++; if (we_count != w0) begin failures++; $display("[TB] FAIL arst_no_write: got %0d ram_we cycles expected 0", we_count - w0); end
    end
    send_req(mk(0, F3_W, B + 32'h40, 32'h0, 32'h0, 2'b00), to);
    if (!to) begin
      get_resp(rd, er, e, lat, to);
      checks++; if (to || rd !== e.rdata || er !== e.err) begin
        failures++; $display("[TB] FAIL arst_reload: got rdata=%h err=%b expected %h/%b", rd, er, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    #12;
    test_reset();
    test_load_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
